score_ctrl: RTL and testbench

SCORE_CTRL -- requirements
Module: score_ctrl

---
 rtl/score_pkg.sv | 44 ++++
 rtl/score_ctrl_bcd_digit.sv | 28 ++
 rtl/score_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_score_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score controller: FSM states, 7-segment patterns, BCD decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Codes 10-15 never occur in a BCD counter; show them as a dark digit
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/score_ctrl_bcd_digit.sv
// One decimal digit of a ripple BCD counter with synchronous clear.
// Latency: digit updates on the Clock edge after inc/clr; carry_out is combinational from inc and the digit register.
// Backpressure: none; inc is consumed every cycle it is high.
//
// Ports: Clock, RST_n (async active-low), clr (sync clear, wins over inc),
//        inc (count enable), digit[3:0] (registered value), carry_out (inc & digit==9).
module bcd_digit (
    input  logic       Clock,
    input  logic       RST_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry_out
);

    assign carry_out = inc & (digit == 4'd9);

    always_ff @(posedge Clock or negedge RST_n) begin
        if (!RST_n) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (inc) begin
            digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/score_ctrl.sv
// Game score controller: IDLE/PLAY/OVER FSM, 3-digit saturating BCD score, optional high score, 7-seg outputs.
// Latency: start/pass/collide act on the next Clock edge; displays follow registers with no input-to-output path.
// Backpressure: none; start and pass are edge-detected, collide is level-sensitive.
//
// Ports: Clock, RST_n (async active-low), start, pass, collide (level inputs),
//        hex0..hex2 score digits, hex3..hex5 high-score digits (ones..hundreds, active-low {g..a}),
//        playing (state is PLAY), score_max (score is 999).
// Build option: define SCORE_HISCORE_EN to include the high-score register; otherwise hex3..hex5 are dark.
module score_ctrl
    import score_pkg::*;
#(
    parameter int OVER_HOLD = 8
) (
    input  logic       Clock,
    input  logic       RST_n,
    input  logic       start,
    input  logic       pass,
    input  logic       collide,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       playing,
    output logic       score_max
);

    // +2 keeps the width at least one bit even for OVER_HOLD = 0
    localparam int HW = $clog2(OVER_HOLD + 2);

    state_t        state_q, state_d;
    logic          start_q, pass_q;
    logic          start_e, pass_e;
    logic [HW-1:0] hold_q;

    logic          clr_score;
    logic          inc_req;
    logic          inc_score;
    logic          load_hold;
    logic          game_end;

    logic [3:0]    d0, d1, d2;
    logic          c0, c1, c2;

    // ---------------- edge detection ----------------
    always_ff @(posedge Clock or negedge RST_n) begin
        if (!RST_n) begin
            start_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            start_q <= start;
            pass_q  <= pass;
        end
    end

    assign start_e = start & ~start_q;
    assign pass_e  = pass  & ~pass_q;

    // ---------------- FSM ----------------
    always_ff @(posedge Clock or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_score = 1'b0;
        inc_req   = 1'b0;
        load_hold = 1'b0;
        game_end  = 1'b0;
        case (state_q)
            IDLE: begin
                clr_score = 1'b1;
                if (start_e) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // collision has priority over a simultaneous pass edge
                if (collide) begin
                    state_d   = OVER;
                    load_hold = 1'b1;
                    game_end  = 1'b1;
                end else if (pass_e) begin
                    inc_req = 1'b1;
                end
            end
            OVER: begin
                if (start_e && (hold_q == '0)) begin
                    state_d   = PLAY;
                    clr_score = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- OVER hold-off counter ----------------
    always_ff @(posedge Clock or negedge RST_n) begin
        if (!RST_n) begin
            hold_q <= '0;
        end else if (load_hold) begin
            hold_q <= HW'(OVER_HOLD);
        end else if ((state_q == OVER) && (hold_q != '0)) begin
            hold_q <= hold_q - 1'b1;
        end
    end

    // ---------------- score counter ----------------
    assign score_max = (d2 == 4'd9) && (d1 == 4'd9) && (d0 == 4'd9);
    // blocking the increment at 999 gives saturation instead of wrap to 000
    assign inc_score = inc_req & ~score_max;

    bcd_digit u_ones (
        .Clock     (Clock),
        .RST_n     (RST_n),
        .clr       (clr_score),
        .inc       (inc_score),
        .digit     (d0),
        .carry_out (c0)
    );

    bcd_digit u_tens (
        .Clock     (Clock),
        .RST_n     (RST_n),
        .clr       (clr_score),
        .inc       (c0),
        .digit     (d1),
        .carry_out (c1)
    );

    bcd_digit u_hund (
        .Clock     (Clock),
        .RST_n     (RST_n),
        .clr       (clr_score),
        .inc       (c1),
        .digit     (d2),
        .carry_out (c2)
    );

    assign playing = (state_q == PLAY);
    assign hex0    = bcd_to_seg(d0);
    assign hex1    = bcd_to_seg(d1);
    assign hex2    = bcd_to_seg(d2);

`ifdef SCORE_HISCORE_EN
    logic [11:0] hi_q;
    logic [11:0] score_bcd;

    // BCD digits concatenated hundreds..ones compare correctly as a plain binary magnitude
    assign score_bcd = {d2, d1, d0};

    always_ff @(posedge Clock or negedge RST_n) begin
        if (!RST_n) begin
            hi_q <= '0;
        end else if (game_end && (score_bcd > hi_q)) begin
            hi_q <= score_bcd;
        end
    end

    assign hex3 = bcd_to_seg(hi_q[3:0]);
    assign hex4 = bcd_to_seg(hi_q[7:4]);
    assign hex5 = bcd_to_seg(hi_q[11:8]);

    logic unused_hi;
    assign unused_hi = c2;
`else
    assign hex3 = SEG_BLANK;
    assign hex4 = SEG_BLANK;
    assign hex5 = SEG_BLANK;

    logic unused_hi;
    assign unused_hi = c2 ^ game_end;
`endif

endmodule

// File: tb/tb_score_ctrl.sv
// Directed testbench for score_ctrl: reset values, scoring with carries, saturation,
// collision priority, high score, OVER hold-off and asynchronous reset.
module tb_score_ctrl;

    localparam int HOLD = 8;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    logic       Clock;
    logic       RST_n;
    logic       start, pass, collide;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       playing, score_max;

    int errors = 0;
    int checks = 0;

    score_ctrl #(.OVER_HOLD(HOLD)) dut (
        .Clock     (Clock),
        .RST_n     (RST_n),
        .start     (start),
        .pass      (pass),
        .collide   (collide),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .hex4      (hex4),
        .hex5      (hex5),
        .playing   (playing),
        .score_max (score_max)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pass_pulses(input int n, input int hold_cycles);
        for (int i = 0; i < n; i++) begin
            pass = 1'b1;
            repeat (hold_cycles) tick();
            pass = 1'b0;
            tick();
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // high-score displays: digits when the feature is built in, dark otherwise
    function automatic logic [6:0] hi_seg(input logic [6:0] s);
`ifdef SCORE_HISCORE_EN
        return s;
`else
        return (s === 7'bxxxxxxx) ? SB : SB;
`endif
    endfunction

    initial begin
        RST_n   = 1'b0;
        start   = 1'b0;
        pass    = 1'b0;
        collide = 1'b0;
        #12;

        // ---- reset values ----
        chk("rst_hex0", hex0, S0);
        chk("rst_hex1", hex1, S0);
        chk("rst_hex2", hex2, S0);
        chk("rst_hex3", hex3, hi_seg(S0));
        chk("rst_hex5", hex5, hi_seg(S0));
        chk("rst_playing", playing, 0);
        chk("rst_max", score_max, 0);

        tick();
        RST_n = 1'b1;
        tick();

        // ---- pass ignored in IDLE, then start ----
        pass_pulses(1, 1);
        chk("idle_pass_ignored", hex0, S0);
        start = 1'b1;
        tick();
        chk("start_to_play", playing, 1);
        start = 1'b0;
        tick();

        // ---- three long pass pulses count once each ----
        pass_pulses(3, 4);
        chk("s3_hex0", hex0, S3);
        chk("s3_hex1", hex1, S0);
        chk("s3_hex2", hex2, S0);
        chk("s3_playing", playing, 1);

        // ---- 012 ----
        pass_pulses(9, 1);
        chk("s12_hex0", hex0, S2);
        chk("s12_hex1", hex1, S1);

        // ---- 099 -> 100 ----
        pass_pulses(87, 1);
        chk("s99_hex0", hex0, S9);
        chk("s99_hex1", hex1, S9);
        chk("s99_hex2", hex2, S0);
        pass = 1'b1;
        tick();
        chk("s100_hex2", hex2, S1);
        chk("s100_hex1", hex1, S0);
        chk("s100_hex0", hex0, S0);
        chk("s100_max", score_max, 0);
        pass = 1'b0;
        tick();

        // ---- 999 and saturation ----
        pass_pulses(898, 1);
        chk("s998_max", score_max, 0);
        chk("s998_hex0", hex0, 7'b0000000);
        pass_pulses(1, 1);
        chk("s999_max", score_max, 1);
        chk("s999_hex0", hex0, S9);
        chk("s999_hex2", hex2, S9);
        pass_pulses(1, 1);
        chk("sat_hex0", hex0, S9);
        chk("sat_hex1", hex1, S9);
        chk("sat_hex2", hex2, S9);
        chk("sat_max", score_max, 1);

        // ---- reset mid-PLAY at 999 discards everything ----
        RST_n = 1'b0;
        #1;
        chk("rst999_hex2", hex2, S0);
        chk("rst999_hex3", hex3, hi_seg(S0));
        chk("rst999_playing", playing, 0);
        tick();
        RST_n = 1'b1;
        tick();

        // ---- score 7, collide + pass edge together ----
        start_pulse();
        pass_pulses(7, 1);
        chk("s7_hex0", hex0, S7);
        collide = 1'b1;
        pass    = 1'b1;
        tick();                          // OVER entered, hold = HOLD
        collide = 1'b0;
        pass    = 1'b0;
        chk("over_playing", playing, 0);
        chk("over_hex0", hex0, S7);
        chk("over_hi3", hex3, hi_seg(S7));
        chk("over_hi4", hex4, hi_seg(S0));
        tick();                          // hold 7
        tick();                          // hold 6
        start_pulse();                   // edge seen at hold 6; hold now 4
        chk("early_start_ignored", playing, 0);
        chk("early_start_score", hex0, S7);
        tick();                          // 3
        tick();                          // 2
        tick();                          // 1
        start = 1'b1;
        tick();                          // edge seen at hold 1 -> ignored, hold 0
        chk("hold1_start_ignored", playing, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();                          // edge seen at hold 0 -> PLAY
        chk("hold0_start_play", playing, 1);
        chk("replay_clr_hex0", hex0, S0);
        chk("replay_hi_kept", hex3, hi_seg(S7));
        start = 1'b0;
        tick();

        // ---- replay scoring 5: high score keeps 7 ----
        pass_pulses(5, 2);
        collide = 1'b1;
        tick();
        collide = 1'b0;
        chk("r5_hex0", hex0, S5);
        chk("r5_hi3", hex3, hi_seg(S7));
        pass_pulses(2, 1);
        chk("over_pass_ignored", hex0, S5);

        // ---- score 42 then async reset ----
        repeat (HOLD + 2) tick();
        start_pulse();
        chk("p42_playing", playing, 1);
        pass_pulses(42, 1);
        chk("s42_hex0", hex0, S2);
        chk("s42_hex1", hex1, S4);
        #2;
        RST_n = 1'b0;
        #1;
        chk("async_hex0", hex0, S0);
        chk("async_hex1", hex1, S0);
        chk("async_hex3", hex3, hi_seg(S0));
        chk("async_hex4", hex4, hi_seg(S0));
        chk("async_playing", playing, 0);
        chk("async_max", score_max, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
